dca_matrix_row_streamer: RTL and testbench



---
 rtl/dca_matrix_row_streamer_pkg.sv | 31 +++
 rtl/dca_matrix_row_streamer.sv | 143 ++++++++++++++
 tb/tb_dca_matrix_row_streamer.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dca_matrix_row_streamer_pkg.sv
// Shared definitions for the matrix row streamer: default matrix geometry,
// FSM state encoding and small constant helpers.
package dca_matrix_row_streamer_pkg;

    localparam int DEF_MATRIX_SIZE_PARA = 8;
    localparam int DEF_BW_TENSOR_SCALAR = 32;
    localparam int DEF_MATRIX_NUM_ROW   = DEF_MATRIX_SIZE_PARA;
    localparam int DEF_MATRIX_NUM_COL   = DEF_MATRIX_SIZE_PARA;
    localparam int DEF_BW_TENSOR_ROW    = DEF_MATRIX_NUM_COL * DEF_BW_TENSOR_SCALAR;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FULL  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    function automatic int clog2_f(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int row_width_f(input int num_col, input int bw_scalar);
        return num_col * bw_scalar;
    endfunction

endpackage

// File: rtl/dca_matrix_row_streamer.sv
// Row sequencer in front of the matrix register's row-move port: loads N rows
// from a valid/ready stream and drains them back out, optionally recirculating.
module dca_matrix_row_streamer
    import dca_matrix_row_streamer_pkg::*;
#(
    parameter int  MATRIX_SIZE_PARA = DEF_MATRIX_SIZE_PARA,
    parameter int  BW_TENSOR_SCALAR = DEF_BW_TENSOR_SCALAR,
    localparam int MATRIX_NUM_ROW   = MATRIX_SIZE_PARA,
    localparam int MATRIX_NUM_COL   = MATRIX_SIZE_PARA,
    localparam int BW_TENSOR_ROW    = row_width_f(MATRIX_NUM_COL, BW_TENSOR_SCALAR)
) (
    input  logic                     clk,
    input  logic                     rstnn,
    input  logic                     load_start,
    input  logic                     drain_start,
    input  logic                     drain_keep,
    input  logic                     abort,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [BW_TENSOR_ROW-1:0] s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [BW_TENSOR_ROW-1:0] m_data,
    output logic                     init,
    output logic                     move_wenable,
    output logic [BW_TENSOR_ROW-1:0] move_wdata_list,
    output logic                     move_renable,
    input  logic [BW_TENSOR_ROW-1:0] move_rdata_list,
    output logic                     busy,
    output logic                     matrix_full,
    output logic                     done
);

    localparam int ROW_CNT_W = clog2_f(MATRIX_NUM_ROW + 1);
    localparam logic [ROW_CNT_W-1:0] LAST_ROW = ROW_CNT_W'(MATRIX_NUM_ROW - 1);

    state_e                 state_q, state_d;
    logic [ROW_CNT_W-1:0]   row_cnt_q, row_cnt_d;
    logic                   keep_q, keep_d;
    logic                   done_q, done_d;

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q   <= ST_IDLE;
            row_cnt_q <= '0;
            keep_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            keep_q    <= keep_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        row_cnt_d       = row_cnt_q;
        keep_d          = keep_q;
        done_d          = 1'b0;
        s_ready         = 1'b0;
        m_valid         = 1'b0;
        m_data          = '0;
        init            = 1'b0;
        move_wenable    = 1'b0;
        move_wdata_list = '0;
        move_renable    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d   = ST_LOAD;
                    row_cnt_d = '0;
                    init      = 1'b1;
                end
            end
            ST_LOAD: begin
                s_ready         = 1'b1;
                move_wdata_list = s_data;
                if (s_valid) begin
                    move_wenable = 1'b1;
                    if (row_cnt_q == LAST_ROW) begin
                        row_cnt_d = '0;
                        done_d    = 1'b1;
                        state_d   = ST_FULL;
                    end else begin
                        row_cnt_d = row_cnt_q + ROW_CNT_W'(1);
                    end
                end
            end
            ST_FULL: begin
                // A simultaneous drain request takes precedence over a reload.
                if (drain_start) begin
                    state_d   = ST_DRAIN;
                    keep_d    = drain_keep;
                    row_cnt_d = '0;
                end else if (load_start) begin
                    state_d   = ST_LOAD;
                    row_cnt_d = '0;
                    init      = 1'b1;
                end
            end
            ST_DRAIN: begin
                m_valid = 1'b1;
                m_data  = move_rdata_list;
                if (keep_q) begin
                    move_wdata_list = move_rdata_list;
                end
                if (m_ready) begin
                    move_renable = 1'b1;
                    move_wenable = keep_q;
                    if (row_cnt_q == LAST_ROW) begin
                        row_cnt_d = '0;
                        done_d    = 1'b1;
                        state_d   = keep_q ? ST_FULL : ST_IDLE;
                    end else begin
                        row_cnt_d = row_cnt_q + ROW_CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort suppresses every handshake and strobe so the register is left as-is.
        if (abort) begin
            state_d         = ST_IDLE;
            row_cnt_d       = '0;
            done_d          = 1'b0;
            s_ready         = 1'b0;
            m_valid         = 1'b0;
            m_data          = '0;
            init            = 1'b0;
            move_wenable    = 1'b0;
            move_wdata_list = '0;
            move_renable    = 1'b0;
        end
    end

    assign busy        = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign matrix_full = (state_q == ST_FULL);
    assign done        = done_q;

endmodule

// File: tb/tb_dca_matrix_row_streamer.sv
// Self-checking bench for dca_matrix_row_streamer: a transaction-level model of
// the streamer plus a queue model of the matrix register it drives.
module tb_dca_matrix_row_streamer;

    localparam int N = 8;
    localparam int W = 8 * 32;

    logic         clk;
    logic         rstnn;
    logic         load_start, drain_start, drain_keep, abort;
    logic         s_valid, s_ready;
    logic [W-1:0] s_data;
    logic         m_valid, m_ready;
    logic [W-1:0] m_data;
    logic         init, move_wenable, move_renable;
    logic [W-1:0] move_wdata_list, move_rdata_list;
    logic         busy, matrix_full, done;

    int checks   = 0;
    int failures = 0;

    dca_matrix_row_streamer dut (
        .clk             (clk),
        .rstnn           (rstnn),
        .load_start      (load_start),
        .drain_start     (drain_start),
        .drain_keep      (drain_keep),
        .abort           (abort),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data          (s_data),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_data          (m_data),
        .init            (init),
        .move_wenable    (move_wenable),
        .move_wdata_list (move_wdata_list),
        .move_renable    (move_renable),
        .move_rdata_list (move_rdata_list),
        .busy            (busy),
        .matrix_full     (matrix_full),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic logic [W-1:0] randRow();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Inputs change 1 time unit after the rising edge and hold for the cycle.
    task automatic applyStimulus(input bit ls, input bit ds, input bit dk, input bit ab,
                                 input bit sv, input logic [W-1:0] sd, input bit mr);
        @(posedge clk);
        #1;
        load_start  = ls;
        drain_start = ds;
        drain_keep  = dk;
        abort       = ab;
        s_valid     = sv;
        s_data      = sd;
        m_ready     = mr;
    endtask

    // Matrix register model: rows enter at the bottom, the top row is visible.
    logic [W-1:0] reg_rows[$];
    logic         pend_init, pend_we, pend_re;
    logic [W-1:0] pend_wdata;

    initial begin
        pend_init = 0; pend_we = 0; pend_re = 0; pend_wdata = '0;
        move_rdata_list = '0;
    end

    always @(posedge clk) begin
        if (pend_init) begin
            reg_rows.delete();
        end else begin
            if (pend_re && reg_rows.size() > 0) void'(reg_rows.pop_front());
            if (pend_we) reg_rows.push_back(pend_wdata);
        end
        move_rdata_list <= (reg_rows.size() > 0) ? reg_rows[0] : '0;
    end

    // Streamer model, expressed as what the controller has been asked to do.
    typedef enum {M_IDLE, M_LOADING, M_FULL, M_DRAINING} model_mode_e;
    model_mode_e  m_mode = M_IDLE;
    int           m_rows = 0;
    bit           m_keep = 0;
    bit           m_done_pend = 0;
    logic [W-1:0] golden[$];

    int we_cnt = 0, re_cnt = 0, init_cnt = 0, done_cnt = 0;
    logic [W-1:0] drained[$];

    logic         exp_sready, exp_mvalid, exp_we, exp_re, exp_init;
    logic [W-1:0] exp_wdata, exp_mdata;

    always @(negedge clk) begin
        pend_init  = init;
        pend_we    = move_wenable;
        pend_re    = move_renable;
        pend_wdata = move_wdata_list;
        we_cnt   += int'(move_wenable);
        re_cnt   += int'(move_renable);
        init_cnt += int'(init);
        done_cnt += int'(done);
        if (m_valid && m_ready) drained.push_back(m_data);

        if (!rstnn) begin
            m_mode = M_IDLE; m_rows = 0; m_keep = 0; m_done_pend = 0;
            checkOutput("rst_s_ready", s_ready, 0);
            checkOutput("rst_m_valid", m_valid, 0);
            checkOutput("rst_wenable", move_wenable, 0);
            checkOutput("rst_renable", move_renable, 0);
            checkOutput("rst_full", matrix_full, 0);
            checkOutput("rst_done", done, 0);
            checkOutput("rst_busy", busy, 0);
        end else begin
            exp_sready = 0; exp_mvalid = 0; exp_we = 0; exp_re = 0; exp_init = 0;
            exp_wdata = '0; exp_mdata = '0;
            if (!abort) begin
                case (m_mode)
                    M_IDLE:  exp_init = load_start;
                    M_FULL:  exp_init = load_start && !drain_start;
                    M_LOADING: begin
                        exp_sready = 1;
                        exp_we     = s_valid;
                        exp_wdata  = s_data;
                    end
                    M_DRAINING: begin
                        exp_mvalid = 1;
                        exp_mdata  = golden[m_rows];
                        exp_re     = m_ready;
                        exp_we     = m_ready && m_keep;
                        exp_wdata  = golden[m_rows];
                    end
                endcase
            end
            checkOutput("s_ready", s_ready, exp_sready);
            checkOutput("m_valid", m_valid, exp_mvalid);
            checkOutput("move_wenable", move_wenable, exp_we);
            checkOutput("move_renable", move_renable, exp_re);
            checkOutput("init", init, exp_init);
            checkOutput("busy", busy, (m_mode == M_LOADING || m_mode == M_DRAINING));
            checkOutput("matrix_full", matrix_full, (m_mode == M_FULL));
            checkOutput("done", done, m_done_pend);
            if (exp_mvalid) checkOutput("m_data", m_data, exp_mdata);
            if (exp_we || abort || m_mode == M_IDLE || m_mode == M_FULL)
                checkOutput("move_wdata_list", move_wdata_list, exp_wdata);

            m_done_pend = 0;
            if (abort) begin
                m_mode = M_IDLE;
                m_rows = 0;
            end else begin
                case (m_mode)
                    M_IDLE: if (load_start) begin
                        m_mode = M_LOADING; m_rows = 0; golden.delete();
                    end
                    M_FULL: if (drain_start) begin
                        m_mode = M_DRAINING; m_keep = drain_keep; m_rows = 0;
                    end else if (load_start) begin
                        m_mode = M_LOADING; m_rows = 0; golden.delete();
                    end
                    M_LOADING: if (s_valid) begin
                        golden.push_back(s_data);
                        m_rows++;
                        if (m_rows == N) begin
                            m_mode = M_FULL; m_rows = 0; m_done_pend = 1;
                        end
                    end
                    M_DRAINING: if (m_ready) begin
                        m_rows++;
                        if (m_rows == N) begin
                            m_rows = 0; m_done_pend = 1;
                            m_mode = m_keep ? M_FULL : M_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    // Drive rows/handshakes until one done pulse appears; vmode 0=held, 1=random, 2=toggle.
    task automatic waitDone(input string name, input int budget, input int vmode, input bit rrand);
        int start;
        bit sv;
        start = done_cnt;
        for (int i = 0; i < budget && done_cnt == start; i++) begin
            sv = (vmode == 0) ? 1'b1 : (vmode == 1) ? 1'($urandom % 2) : 1'(i % 2 == 0);
            applyStimulus(0, 0, 0, 0, sv, randRow(), rrand ? 1'($urandom % 2) : 1'b1);
        end
        checkOutput({name, "_done_seen"}, (done_cnt != start), 1);
        applyStimulus(0, 0, 0, 0, 0, '0, 0);
    endtask

    int we0, re0, init0, done0;

    initial begin
        rstnn = 0;
        load_start = 0; drain_start = 0; drain_keep = 0; abort = 0;
        s_valid = 0; s_data = '0; m_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_full", matrix_full, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_init", init, 0);
        rstnn = 1;

        // Directed load of rows 0..7 with s_valid held.
        we0 = we_cnt; init0 = init_cnt; done0 = done_cnt;
        applyStimulus(1, 0, 0, 0, 0, '0, 0);
        for (int k = 0; k < N; k++) applyStimulus(0, 0, 0, 0, 1, W'(k), 0);
        applyStimulus(0, 0, 0, 0, 0, '0, 0);
        #1;
        checkOutput("load_done_pulse", done, 1);
        checkOutput("load_full", matrix_full, 1);
        applyStimulus(0, 0, 0, 0, 0, '0, 0);
        #1;
        checkOutput("load_we_count", we_cnt - we0, 8);
        checkOutput("load_init_count", init_cnt - init0, 1);
        checkOutput("load_done_count", done_cnt - done0, 1);

        // Keep-drain twice: both passes must return the same 0..7 sequence.
        for (int pass = 0; pass < 2; pass++) begin
            drained.delete();
            we0 = we_cnt; re0 = re_cnt;
            applyStimulus(0, 1, 1, 0, 0, '0, 1);
            waitDone("keep_drain", 200, 0, pass == 1);
            #1;
            checkOutput("keep_drain_full", matrix_full, 1);
            checkOutput("keep_drain_re_count", re_cnt - re0, 8);
            checkOutput("keep_drain_we_count", we_cnt - we0, 8);
            checkOutput("keep_drain_len", drained.size(), 8);
            for (int k = 0; k < N; k++)
                checkOutput($sformatf("keep_drain_row%0d", k), (drained.size() > k) ? drained[k] : '1, W'(k));
        end

        // Destructive drain with random back-pressure.
        we0 = we_cnt; re0 = re_cnt;
        applyStimulus(0, 1, 0, 0, 0, '0, 0);
        waitDone("plain_drain", 300, 0, 1);
        #1;
        checkOutput("plain_drain_full", matrix_full, 0);
        checkOutput("plain_drain_busy", busy, 0);
        checkOutput("plain_drain_re_count", re_cnt - re0, 8);
        checkOutput("plain_drain_we_count", we_cnt - we0, 0);

        // Load with toggling s_valid.
        we0 = we_cnt;
        applyStimulus(1, 0, 0, 0, 0, '0, 0);
        waitDone("toggle_load", 100, 2, 0);
        #1;
        checkOutput("toggle_load_we_count", we_cnt - we0, 8);
        checkOutput("toggle_load_full", matrix_full, 1);

        // Abort after three rows of an overwrite load, then a fresh load.
        done0 = done_cnt;
        applyStimulus(1, 0, 0, 0, 0, '0, 0);
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 1, randRow(), 0);
        applyStimulus(0, 0, 0, 1, 1, randRow(), 0);
        applyStimulus(0, 0, 0, 0, 1, randRow(), 0);
        #1;
        checkOutput("abort_s_ready", s_ready, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_full", matrix_full, 0);
        applyStimulus(0, 0, 0, 0, 0, '0, 0);
        checkOutput("abort_no_done", done_cnt - done0, 0);
        init0 = init_cnt;
        applyStimulus(1, 0, 0, 0, 0, '0, 0);
        waitDone("reload", 100, 1, 0);
        checkOutput("reload_init_count", init_cnt - init0, 1);

        // Asynchronous reset in the middle of a drain.
        applyStimulus(0, 1, 0, 0, 0, '0, 1);
        for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 0, 0, '0, 1);
        #1;
        rstnn = 0;
        #1;
        checkOutput("async_rst_m_valid", m_valid, 0);
        checkOutput("async_rst_renable", move_renable, 0);
        checkOutput("async_rst_full", matrix_full, 0);
        repeat (2) @(posedge clk);
        #1;
        rstnn = 1;
        m_ready = 0;
        applyStimulus(0, 0, 0, 0, 0, '0, 0);
        #1;
        checkOutput("post_rst_busy", busy, 0);
        checkOutput("post_rst_full", matrix_full, 0);

        // Random traffic; the compare process checks every cycle.
        for (int i = 0; i < 800; i++) begin
            applyStimulus(1'($urandom % 8 == 0), 1'($urandom % 6 == 0), 1'($urandom % 2),
                          1'($urandom % 50 == 0), 1'($urandom % 2), randRow(), 1'($urandom % 2));
        end
        applyStimulus(0, 0, 0, 0, 0, '0, 0);
        applyStimulus(0, 0, 0, 0, 0, '0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
